fp_multiplier_param: RTL and testbench

//  Parametrised IEEE-754-style floating-point multiplier with stb/ack handshakes per operand and result.

---
 rtl/fp_multiplier_param_if.sv | 47 ++++
 rtl/fp_multiplier_param.sv | 236 +++++++++++++++++++++++
 tb/tb_fp_multiplier_param.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_multiplier_param_if.sv
// ---------------------------------------------------------------------------
// fp_multiplier_param_if
//   Operand/result handshake bundle for fp_multiplier_param.
//   Each channel uses stb/ack: a word moves on a rising clk edge where both
//   stb and ack are high.
//
//   Parameter
//     W             word width (1 + EXP_W + FRAC_W)
//
//   Signals
//     input_a       operand A          (producer -> multiplier)
//     input_a_stb   operand A valid    (producer -> multiplier)
//     input_a_ack   operand A ready    (multiplier -> producer)
//     input_b       operand B          (producer -> multiplier)
//     input_b_stb   operand B valid    (producer -> multiplier)
//     input_b_ack   operand B ready    (multiplier -> producer)
//     output_z      product            (multiplier -> consumer)
//     output_z_stb  product valid      (multiplier -> consumer)
//     output_z_ack  product consumed   (consumer -> multiplier)
//
//   Modports
//     master        operand producer / result consumer side
//     slave         multiplier side
// ---------------------------------------------------------------------------
interface fp_multiplier_param_if #(
  parameter int W = 32
);
  logic [W-1:0] input_a;
  logic         input_a_stb;
  logic         input_a_ack;
  logic [W-1:0] input_b;
  logic         input_b_stb;
  logic         input_b_ack;
  logic [W-1:0] output_z;
  logic         output_z_stb;
  logic         output_z_ack;

  modport master (
    output input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
    input  input_a_ack, input_b_ack, output_z, output_z_stb
  );

  modport slave (
    input  input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
    output input_a_ack, input_b_ack, output_z, output_z_stb
  );
endinterface

// File: rtl/fp_multiplier_param.sv
// ---------------------------------------------------------------------------
// fp_multiplier_param
//   Parametrised IEEE-754-style multiplier, round-to-nearest-even, with full
//   NaN / Inf / zero handling. One operation at a time, one FSM state per
//   cycle: GET_A, GET_B, UNPACK, SPECIAL, MULTIPLY, NORMALISE, ROUND, PACK,
//   PUT_Z. output_z_stb rises 7 cycles after the B transfer edge for normal
//   operands and 3 cycles after it for special operands.
//
//   Parameters
//     EXP_W   exponent field width (>= 3)
//     FRAC_W  stored fraction width (>= 2)
//
//   Ports
//     clk     rising-edge clock
//     rst     asynchronous, active-high reset; aborts any operation
//     bus     fp_multiplier_param_if.slave (A, B, Z stb/ack channels)
//
//   Build option
//     FPMUL_DENORM_EN  defined: subnormal inputs and results are supported,
//                      NORMALISE iterates and latency becomes variable.
//                      undefined: subnormals flush to signed zero, latency
//                      is fixed.
// ---------------------------------------------------------------------------
module fp_multiplier_param #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input logic                  clk,
  input logic                  rst,
  fp_multiplier_param_if.slave bus
);
  localparam int W    = 1 + EXP_W + FRAC_W;
  localparam int EW   = EXP_W + 2;        // signed unbiased exponent width
  localparam int MW   = FRAC_W + 1;       // mantissa with hidden bit
  localparam int PW   = 2 * MW;           // full product, value in [1,4)
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam logic signed [EW-1:0] EMAX = EW'(BIAS);
  localparam logic signed [EW-1:0] EMIN = EW'(1 - BIAS);
  // Product bits below round bit feed sticky.
  localparam logic [PW-1:0] LOW_MASK = (PW'(1) << (FRAC_W - 2)) - PW'(1);

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, MULTIPLY, NORMALISE, ROUND, PACK, PUT_Z
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]         a_q, b_q, z_q;
  logic                 z_stb_q;
  logic                 a_s, b_s, z_s;
  logic signed [EW-1:0] a_e, b_e, z_e;
  logic [MW-1:0]        a_m, b_m, z_m;
  logic [PW-1:0]        prod;
  logic                 sticky_q;
  logic                 a_ack, b_ack;

  // Raw field views used by UNPACK and SPECIAL.
  logic [EXP_W-1:0]  a_exp, b_exp;
  logic [FRAC_W-1:0] a_frac, b_frac;
  assign a_exp  = a_q[W-2 -: EXP_W];
  assign b_exp  = b_q[W-2 -: EXP_W];
  assign a_frac = a_q[FRAC_W-1:0];
  assign b_frac = b_q[FRAC_W-1:0];

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special_hit;
  assign a_nan = (&a_exp) && (|a_frac);
  assign b_nan = (&b_exp) && (|b_frac);
  assign a_inf = (&a_exp) && !(|a_frac);
  assign b_inf = (&b_exp) && !(|b_frac);
`ifdef FPMUL_DENORM_EN
  assign a_zero = (a_exp == '0) && (a_frac == '0);
  assign b_zero = (b_exp == '0) && (b_frac == '0);
`else
  // Subnormal inputs are treated as signed zero.
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
`endif
  assign special_hit = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  logic [W-1:0] sp_z;
  logic         sp_sign;
  assign sp_sign = a_q[W-1] ^ b_q[W-1];

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    sp_z = {sp_sign, {(W-1){1'b0}}};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      sp_z = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
    else if (a_inf || b_inf)
      sp_z = {sp_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  end

  // Normalisation. The product hidden bit ends up at PW-2.
  logic norm_done;
`ifdef FPMUL_DENORM_EN
  localparam logic signed [EW-1:0] EMIN_M1 = EMIN - EW'(1);
  logic [EW-1:0] dn_amt;
  logic [PW-1:0] dn_mask;
  assign dn_amt    = EMIN - z_e;          // only used while z_e < EMIN
  assign dn_mask   = ~({PW{1'b1}} << dn_amt);
  assign norm_done = prod[PW-1] ? (z_e >= EMIN_M1) : (prod[PW-2] || z_e <= EMIN);
`else
  assign norm_done = 1'b1;
`endif

  // Round to nearest, ties to even.
  logic [MW-1:0] mant;
  logic [MW:0]   mant_inc;
  logic          g_bit, r_bit, s_bit, round_up;
  assign mant     = prod[PW-2 -: MW];
  assign g_bit    = prod[FRAC_W-1];
  assign r_bit    = prod[FRAC_W-2];
  assign s_bit    = sticky_q | (|(prod & LOW_MASK));
  assign round_up = g_bit && (r_bit || s_bit || mant[0]);
  assign mant_inc = {1'b0, mant} + (MW+1)'(1);

  // Pack: overflow to Inf, underflow per build option, else rebias.
  logic signed [EW-1:0] z_e_b;
  logic [EXP_W-1:0]     pk_exp;
  logic [W-1:0]         pk_z;
  assign z_e_b = z_e + EMAX;
`ifdef FPMUL_DENORM_EN
  assign pk_exp = z_m[FRAC_W] ? z_e_b[EXP_W-1:0] : '0;
`else
  assign pk_exp = z_e_b[EXP_W-1:0];
`endif

  always_comb begin
    pk_z = {z_s, pk_exp, z_m[FRAC_W-1:0]};
    if (z_e > EMAX)
      pk_z = {z_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
`ifndef FPMUL_DENORM_EN
    else if (z_e < EMIN)
      pk_z = {z_s, {(W-1){1'b0}}};
`endif
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx = state;
    a_ack    = 1'b0;
    b_ack    = 1'b0;
    unique case (state)
      GET_A: begin
        a_ack = 1'b1;
        if (bus.input_a_stb) state_nx = GET_B;
      end
      GET_B: begin
        b_ack = 1'b1;
        if (bus.input_b_stb) state_nx = UNPACK;
      end
      UNPACK:    state_nx = SPECIAL;
      SPECIAL:   state_nx = special_hit ? PUT_Z : MULTIPLY;
      MULTIPLY:  state_nx = NORMALISE;
      NORMALISE: if (norm_done) state_nx = ROUND;
      ROUND:     state_nx = PACK;
      PACK:      state_nx = PUT_Z;
      PUT_Z:     if (z_stb_q && bus.output_z_ack) state_nx = GET_A;
      default:   state_nx = GET_A;
    endcase
  end

  assign bus.input_a_ack  = a_ack;
  assign bus.input_b_ack  = b_ack;
  assign bus.output_z     = z_q;
  assign bus.output_z_stb = z_stb_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= GET_A;
      z_stb_q <= 1'b0;
      z_q     <= '0;
    end else begin
      state <= state_nx;
      if (state == SPECIAL && special_hit) z_q <= sp_z;
      if (state == PACK)                   z_q <= pk_z;
      // stb rises one cycle into PUT_Z and drops on the transfer edge.
      if (state == PUT_Z) z_stb_q <= !(z_stb_q && bus.output_z_ack);
    end
  end

  // NOTE: datapath registers carry no reset; the FSM never reads them before
  // loading them, so a reset would only cost routing.
  always_ff @(posedge clk) begin
    unique case (state)
      GET_A: if (bus.input_a_stb) a_q <= bus.input_a;
      GET_B: if (bus.input_b_stb) b_q <= bus.input_b;
      UNPACK: begin
        a_s <= a_q[W-1];
        b_s <= b_q[W-1];
        a_e <= (a_exp == '0) ? EMIN : signed'({2'b00, a_exp}) - EMAX;
        b_e <= (b_exp == '0) ? EMIN : signed'({2'b00, b_exp}) - EMAX;
        a_m <= {a_exp != '0, a_frac};
        b_m <= {b_exp != '0, b_frac};
      end
      MULTIPLY: begin
        prod     <= PW'(a_m) * PW'(b_m);
        z_e      <= a_e + b_e;
        z_s      <= a_s ^ b_s;
        sticky_q <= 1'b0;
      end
      NORMALISE: begin
        if (prod[PW-1]) begin
          prod     <= prod >> 1;
          sticky_q <= sticky_q | prod[0];
          z_e      <= z_e + EW'(1);
        end
`ifdef FPMUL_DENORM_EN
        else if (!prod[PW-2] && z_e > EMIN) begin
          prod <= prod << 1;
          z_e  <= z_e - EW'(1);
        end else if (z_e < EMIN) begin
          // Shift into the subnormal range in one step, keeping lost bits.
          prod     <= prod >> dn_amt;
          sticky_q <= sticky_q | (|(prod & dn_mask));
          z_e      <= EMIN;
        end
`endif
      end
      ROUND: begin
        if (round_up && mant_inc[MW]) begin
          z_m <= mant_inc[MW:1];
          z_e <= z_e + EW'(1);
        end else if (round_up) begin
          z_m <= mant_inc[MW-1:0];
        end else begin
          z_m <= mant;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fp_multiplier_param.sv
// ---------------------------------------------------------------------------
// tb_fp_multiplier_param
//   Directed vectors for a binary32 and a binary16 instance. Drivers push the
//   hand-computed product (and expected stb latency, 0 = not checked) into a
//   per-instance queue at the B transfer; monitors pop and compare whenever a
//   result is presented.
// ---------------------------------------------------------------------------
module tb_fp_multiplier_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_miss = 0;

  typedef struct {
    logic [31:0] z;
    int          b_cyc;
    int          lat;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];
  exp_t e32, e16;

  fp_multiplier_param_if #(.W(32)) b32 ();
  fp_multiplier_param_if #(.W(16)) b16 ();

  fp_multiplier_param #(.EXP_W(8), .FRAC_W(23)) u_sp (.clk(clk), .rst(rst), .bus(b32));
  fp_multiplier_param #(.EXP_W(5), .FRAC_W(10)) u_hp (.clk(clk), .rst(rst), .bus(b16));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_miss++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Monitors
  logic prev32 = 1'b0, prev16 = 1'b0;
  int   rise32 = 0, rise16 = 0;

  always @(negedge clk) begin
    if (rst) prev32 = 1'b0;
    else begin
      if (b32.output_z_stb && !prev32) rise32 = cyc;
      prev32 = b32.output_z_stb;
      if (b32.output_z_stb) begin
        if (q32.size() == 0) check("z32_unexpected", 32'(b32.output_z_stb), 32'd0);
        else if (b32.output_z_ack) begin
          e32 = q32.pop_front();
          check("z32", b32.output_z, e32.z);
          if (e32.lat != 0) check("lat32", 32'(rise32 - e32.b_cyc), 32'(e32.lat));
        end else check("z32_hold", b32.output_z, q32[0].z);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) prev16 = 1'b0;
    else begin
      if (b16.output_z_stb && !prev16) rise16 = cyc;
      prev16 = b16.output_z_stb;
      if (b16.output_z_stb) begin
        if (q16.size() == 0) check("z16_unexpected", 32'(b16.output_z_stb), 32'd0);
        else if (b16.output_z_ack) begin
          e16 = q16.pop_front();
          check("z16", 32'(b16.output_z), e16.z);
          if (e16.lat != 0) check("lat16", 32'(rise16 - e16.b_cyc), 32'(e16.lat));
        end
      end
    end
  end

  // Drivers: inputs change 1 time unit after the rising edge.
  task automatic issue32(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] z, input int lat, input bit push);
    int n;
    @(posedge clk); #1;
    b32.input_a = a; b32.input_a_stb = 1'b1;
    n = 0;
    @(negedge clk);
    while (!b32.input_a_ack && n < 200) begin @(negedge clk); n++; end
    if (!b32.input_a_ack) begin timeout("a32_ack"); b32.input_a_stb = 1'b0; return; end
    check("a32_excl_b", 32'(b32.input_b_ack), 32'd0);
    @(posedge clk); #1;
    b32.input_a_stb = 1'b0;
    b32.input_b = b; b32.input_b_stb = 1'b1;
    n = 0;
    @(negedge clk);
    while (!b32.input_b_ack && n < 200) begin @(negedge clk); n++; end
    if (!b32.input_b_ack) begin timeout("b32_ack"); b32.input_b_stb = 1'b0; return; end
    @(posedge clk); #1;
    b32.input_b_stb = 1'b0;
    if (push) q32.push_back('{z, cyc, lat});
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] z, input int lat);
    int n;
    @(posedge clk); #1;
    b16.input_a = a; b16.input_a_stb = 1'b1;
    n = 0;
    @(negedge clk);
    while (!b16.input_a_ack && n < 200) begin @(negedge clk); n++; end
    if (!b16.input_a_ack) begin timeout("a16_ack"); b16.input_a_stb = 1'b0; return; end
    @(posedge clk); #1;
    b16.input_a_stb = 1'b0;
    b16.input_b = b; b16.input_b_stb = 1'b1;
    n = 0;
    @(negedge clk);
    while (!b16.input_b_ack && n < 200) begin @(negedge clk); n++; end
    if (!b16.input_b_ack) begin timeout("b16_ack"); b16.input_b_stb = 1'b0; return; end
    @(posedge clk); #1;
    b16.input_b_stb = 1'b0;
    q16.push_back('{32'(z), cyc, lat});
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q16.size() != 0) && n < 500) begin @(negedge clk); n++; end
    if (q32.size() != 0 || q16.size() != 0) timeout("drain");
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_a_ack"}, 32'(b32.input_a_ack), 32'd1);
    check({tag, "_b_ack"}, 32'(b32.input_b_ack), 32'd0);
    check({tag, "_stb"},   32'(b32.output_z_stb), 32'd0);
    check({tag, "_z"},     b32.output_z, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    b32.input_a = '0; b32.input_a_stb = 1'b0; b32.input_b = '0; b32.input_b_stb = 1'b0;
    b32.output_z_ack = 1'b1;
    b16.input_a = '0; b16.input_a_stb = 1'b0; b16.input_b = '0; b16.input_b_stb = 1'b0;
    b16.output_z_ack = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("rst32");
    check("rst16_a_ack", 32'(b16.input_a_ack), 32'd1);
    check("rst16_b_ack", 32'(b16.input_b_ack), 32'd0);
    check("rst16_stb",   32'(b16.output_z_stb), 32'd0);
    check("rst16_z",     32'(b16.output_z), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // binary32 directed vectors
    issue32(32'h3FDEB852, 32'hC10C1893, 32'hC173C45C, 7, 1'b1);
    issue32(32'h40000000, 32'h40400000, 32'h40C00000, 7, 1'b1);
    issue32(32'h7F800000, 32'h00000000, 32'h7FC00000, 3, 1'b1);
    issue32(32'h7F000000, 32'h7F000000, 32'h7F800000, 7, 1'b1);
    issue32(32'h80000000, 32'h3F800000, 32'h80000000, 3, 1'b1);
    issue32(32'h7FC12345, 32'h3F800000, 32'h7FC00000, 3, 1'b1);
    issue32(32'h7F800000, 32'hC0000000, 32'hFF800000, 3, 1'b1);
    issue32(32'h3FC00000, 32'h3FC00000, 32'h40100000, 7, 1'b1);
    issue32(32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 7, 1'b1);
`ifdef FPMUL_DENORM_EN
    issue32(32'h00800000, 32'h3F000000, 32'h00400000, 0, 1'b1);
    issue32(32'h00000001, 32'h3F800000, 32'h00000001, 0, 1'b1);
`else
    issue32(32'h00800000, 32'h3F000000, 32'h00000000, 7, 1'b1);
    issue32(32'h00000001, 32'h3F800000, 32'h00000000, 3, 1'b1);
`endif
    drain();

    // Backpressure: result must hold while ack is low.
    @(posedge clk); #1 b32.output_z_ack = 1'b0;
    issue32(32'h40000000, 32'h40400000, 32'h40C00000, 7, 1'b1);
    n = 0;
    while (!b32.output_z_stb && n < 50) begin @(negedge clk); n++; end
    if (!b32.output_z_stb) timeout("bp_stb");
    for (int i = 0; i < 5; i++) begin
      check("bp_stb_held", 32'(b32.output_z_stb), 32'd1);
      check("bp_a_ack", 32'(b32.input_a_ack), 32'd0);
      check("bp_b_ack", 32'(b32.input_b_ack), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 b32.output_z_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_stb_drop", 32'(b32.output_z_stb), 32'd0);
    check("bp_a_ack_up", 32'(b32.input_a_ack), 32'd1);

    // Reset in MULTIPLY aborts the operation.
    issue32(32'h3FDEB852, 32'hC10C1893, 32'h0, 0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    @(posedge clk); #1 rst = 1'b0;
    issue32(32'h3FDEB852, 32'hC10C1893, 32'hC173C45C, 7, 1'b1);
    drain();

    // binary16 directed vectors
    issue16(16'h4000, 16'h4200, 16'h4600, 7);
    issue16(16'h3E00, 16'h3E00, 16'h4080, 7);
    issue16(16'h3C20, 16'h3C10, 16'h3C30, 7);
    issue16(16'h3C01, 16'h3E00, 16'h3E02, 7);
    issue16(16'h7C00, 16'h0000, 16'h7E00, 3);
    issue16(16'h7800, 16'h7800, 16'h7C00, 7);
    issue16(16'h8000, 16'h3C00, 16'h8000, 3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
